sr_using_jk: RTL and testbench

Positive-edge SR flip-flop built from an internal JK flip-flop. An input-mapping stage converts the S/R pair into J/K, and the JK core holds the state. The block serves as a reusable storage primitive in the flip-flop-conversion library. A WIDTH parameter replicates independent bit-slices.

---
 rtl/sr_using_jk_pkg.sv | 31 +++
 rtl/sr_using_jk_if.sv | 13 +
 rtl/sr_using_jk_jk_ff.sv | 39 +++
 rtl/sr_using_jk.sv | 35 +++
 tb/tb_sr_using_jk.sv | 107 ++++++++++
 5 files changed

// File: rtl/sr_using_jk_pkg.sv
// sr_jk_pkg: shared encodings for the SR-from-JK flip-flop library cell.
//   SR commands are encoded {s,r}; JK commands are encoded {j,k}.
//   sr2jk() is the per-bit input-mapping stage. It never yields JK_TOG.
package sr_jk_pkg;

   localparam logic [1:0] SR_HOLD    = 2'b00;
   localparam logic [1:0] SR_RESET   = 2'b01;
   localparam logic [1:0] SR_SET     = 2'b10;
   localparam logic [1:0] SR_ILLEGAL = 2'b11;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_CLR  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TOG  = 2'b11;

   localparam logic Q_RST = 1'b0;

   // J = s & ~r, K = r & ~s. The forbidden S=R=1 case maps to hold so the
   // core never toggles.
   function automatic logic [1:0] sr2jk(input logic [1:0] sr);
      logic [1:0] jk;
      case (sr)
         SR_RESET: jk = JK_CLR;
         SR_SET:   jk = JK_SET;
         SR_HOLD:  jk = JK_HOLD;
         default:  jk = JK_HOLD;  // SR_ILLEGAL
      endcase
      return jk;
   endfunction

endpackage

// File: rtl/sr_using_jk_if.sv
// sr_using_jk_if: groups the per-bit SR data signals of one sr_using_jk
// instance.
//   master: drives s/r and observes q/qb (the user of the flip-flop).
//   slave : the flip-flop side.
interface sr_using_jk_if #(parameter int WIDTH = 1);
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qb;

   modport master (output s, r, input  q, qb);
   modport slave  (input  s, r, output q, qb);
endinterface

// File: rtl/sr_using_jk_jk_ff.sv
// jk_ff: single-bit positive-edge JK flip-flop with synchronous active-low reset.
//   clk : clock.
//   rst : synchronous reset, active low. It forces q to Q_RST.
//   j,k : JK command; 00 hold, 01 clear, 10 set, 11 toggle.
//   q   : registered state.
//   qb  : ~q, combinational. It is never a separate register.
module jk_ff
   import sr_jk_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qb
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q;
      case ({j, k})
         JK_CLR:  q_d = 1'b0;
         JK_SET:  q_d = 1'b1;
         JK_TOG:  q_d = ~q_q;
         default: q_d = q_q;  // JK_HOLD
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) q_q <= Q_RST;
      else      q_q <= q_d;
   end

   assign q  = q_q;
   assign qb = ~q_q;

endmodule

// File: rtl/sr_using_jk.sv
// sr_using_jk: WIDTH independent positive-edge SR flip-flops, each built
// from a jk_ff and the sr2jk input mapping.
//   s, r : per-bit set/reset requests. S=R=1 is treated as hold.
//   clk  : clock.
//   rst  : synchronous reset, active low. It dominates s/r and clears q.
//   q    : registered state.
//   qb   : ~q.
module sr_using_jk
   import sr_jk_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      logic [1:0] jk;
      assign jk = sr2jk({s[i], r[i]});

      jk_ff u_jk (
         .clk (clk),
         .rst (rst),
         .j   (jk[1]),
         .k   (jk[0]),
         .q   (q[i]),
         .qb  (qb[i])
      );
   end

endmodule

// File: tb/tb_sr_using_jk.sv
// tb_sr_using_jk: directed plus randomized check of sr_using_jk (WIDTH=4)
// against a rule-level reference model of an SR flip-flop.
module tb_sr_using_jk;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [W-1:0] mdl_q;  // reference state

   sr_using_jk_if #(.WIDTH(W)) bus ();

   sr_using_jk #(.WIDTH(W)) dut (
      .s   (bus.s),
      .r   (bus.r),
      .clk (clk),
      .rst (rst),
      .q   (bus.q),
      .qb  (bus.qb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   // Drive inputs while clk is low, take one rising edge, advance the model
   // from the SR rules, then check q/qb shortly after the edge.
   task automatic step(input string tag, input logic rst_v,
                       input logic [W-1:0] s_v, input logic [W-1:0] r_v);
      @(negedge clk);
      rst   = rst_v;
      bus.s = s_v;
      bus.r = r_v;
      @(posedge clk);
      for (int b = 0; b < W; b++) begin
         if (!rst_v)                  mdl_q[b] = 1'b0;
         else if (s_v[b] && !r_v[b])  mdl_q[b] = 1'b1;
         else if (r_v[b] && !s_v[b])  mdl_q[b] = 1'b0;
         // s=r=0 or s=r=1: state is kept
      end
      #1;
      chk({tag, ".q"},  bus.q,  mdl_q);
      chk({tag, ".qb"}, bus.qb, ~mdl_q);
   endtask

   initial begin
      logic [W-1:0] rs, rr;
      mdl_q = '0;
      bus.s = '0;
      bus.r = '0;

      // reset dominates s=1
      step("rst0", 1'b0, 4'b1111, 4'b0000);
      step("rst1", 1'b0, 4'b1111, 4'b0000);

      // set, then hold
      step("set",   1'b1, 4'b1111, 4'b0000);
      step("hold0", 1'b1, 4'b0000, 4'b0000);
      step("hold1", 1'b1, 4'b0000, 4'b0000);

      // no combinational path from s/r to q
      @(negedge clk);
      bus.r = 4'b1111;
      #1;
      chk("nocomb", bus.q, 4'b1111);

      // reset command, held
      step("clr0", 1'b1, 4'b0000, 4'b1111);
      step("clr1", 1'b1, 4'b0000, 4'b1111);

      // forbidden combination from q=0, then from q=1
      step("ill0a", 1'b1, 4'b1111, 4'b1111);
      step("ill0b", 1'b1, 4'b1111, 4'b1111);
      step("set2",  1'b1, 4'b1111, 4'b0000);
      step("ill1a", 1'b1, 4'b1111, 4'b1111);
      step("ill1b", 1'b1, 4'b1111, 4'b1111);

      // mid-operation reset with s=1, then release with s=1
      step("midrst", 1'b0, 4'b1111, 4'b0000);
      step("relset", 1'b1, 4'b1111, 4'b0000);

      // independent slices
      step("mix",    1'b1, 4'b1010, 4'b0101);
      chk("mix.lit", bus.q, 4'b1010);
      step("mixill", 1'b1, 4'b0011, 4'b0011);
      chk("mixill.lit", bus.q, 4'b1010);

      // randomized traffic with occasional resets
      for (int i = 0; i < 300; i++) begin
         rs = W'($urandom);
         rr = W'($urandom);
         step("rand", ($urandom_range(0, 15) != 0), rs, rr);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
